// File: rtl/hit_comb_gen.sv
// Road-level hit combination generator: walks every per-layer hit index
// combination of one road as an odometer and tags it with its fit-constant set.
module hit_comb_gen #(
  parameter int unsigned NLAYER = 5,
  parameter int unsigned CNT_W  = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      road_valid,
  output logic                      road_ready,
  input  logic [NLAYER-1:0]         hitmap_in,
  input  logic [NLAYER-1:0]         lcmap_in,
  input  logic [NLAYER*CNT_W-1:0]   nhits_in,
  output logic                      comb_valid,
  input  logic                      comb_ready,
  output logic [NLAYER*CNT_W-1:0]   comb_sel,
  output logic [NLAYER-1:0]         comb_hitmap,
  output logic [NLAYER-1:0]         comb_lcmap,
  output logic                      comb_first,
  output logic                      comb_last,
  output logic                      comb_err,
  output logic [2:0]                fitset
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e                    state_q;
  logic                      road_ready_q;
  logic                      valid_q;
  logic [NLAYER*CNT_W-1:0]   sel_q;
  logic [NLAYER*CNT_W-1:0]   cnt_q;
  logic [NLAYER-1:0]         hitmap_q;
  logic [NLAYER-1:0]         lcmap_q;
  logic                      first_q;
  logic                      last_q;
  logic                      err_q;
  logic [2:0]                fitset_q;

  // Road decode at capture time
  logic [NLAYER-1:0]         eff_hm;
  logic [NLAYER*CNT_W-1:0]   cnt_eff;
  logic [NLAYER*CNT_W-1:0]   cnt_cap;
  int unsigned               npres;
  logic [2:0]                miss;
  logic [2:0]                fit_cap;
  logic                      err_cap;
  logic                      last_cap;

  // Odometer step
  logic [NLAYER*CNT_W-1:0]   sel_d;
  logic                      last_d;
  logic                      carry;

  always_comb begin
    eff_hm  = '0;
    cnt_eff = '0;
    npres   = 0;
    miss    = '0;
    for (int unsigned i = 0; i < NLAYER; i++) begin
      eff_hm[i] = hitmap_in[i] & (nhits_in[i*CNT_W +: CNT_W] != '0);
      if (eff_hm[i]) begin
        cnt_eff[i*CNT_W +: CNT_W] = nhits_in[i*CNT_W +: CNT_W];
        npres++;
      end else begin
        cnt_eff[i*CNT_W +: CNT_W] = CNT_W'(1);
        miss = 3'(i);
      end
    end
    err_cap = (npres < NLAYER - 1);
    if (npres == NLAYER)
      fit_cap = 3'd5;
    else if (!err_cap)
      fit_cap = miss;
    else
      fit_cap = 3'd7;
    // An error road is forced to a single all-zero combination
    cnt_cap = cnt_eff;
    if (err_cap) begin
      for (int unsigned i = 0; i < NLAYER; i++)
        cnt_cap[i*CNT_W +: CNT_W] = CNT_W'(1);
    end
    last_cap = 1'b1;
    for (int unsigned i = 0; i < NLAYER; i++)
      if (cnt_cap[i*CNT_W +: CNT_W] != CNT_W'(1)) last_cap = 1'b0;
  end

  always_comb begin
    sel_d  = sel_q;
    carry  = 1'b1;
    last_d = 1'b1;
    for (int unsigned i = 0; i < NLAYER; i++) begin
      if (carry) begin
        if (sel_q[i*CNT_W +: CNT_W] == cnt_q[i*CNT_W +: CNT_W] - CNT_W'(1)) begin
          sel_d[i*CNT_W +: CNT_W] = '0;
        end else begin
          sel_d[i*CNT_W +: CNT_W] = sel_q[i*CNT_W +: CNT_W] + CNT_W'(1);
          carry = 1'b0;
        end
      end
      if (sel_d[i*CNT_W +: CNT_W] != cnt_q[i*CNT_W +: CNT_W] - CNT_W'(1))
        last_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      road_ready_q <= 1'b1;
      valid_q      <= 1'b0;
      sel_q        <= '0;
      cnt_q        <= '0;
      hitmap_q     <= '0;
      lcmap_q      <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      fitset_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (road_valid && road_ready_q) begin
            state_q      <= S_RUN;
            road_ready_q <= 1'b0;
            valid_q      <= 1'b1;
            sel_q        <= '0;
            cnt_q        <= cnt_cap;
            hitmap_q     <= eff_hm;
            lcmap_q      <= lcmap_in & eff_hm;
            first_q      <= 1'b1;
            last_q       <= last_cap;
            err_q        <= err_cap;
            fitset_q     <= fit_cap;
          end
        end
        S_RUN: begin
          if (valid_q && comb_ready) begin
            if (last_q) begin
              state_q      <= S_IDLE;
              road_ready_q <= 1'b1;
              valid_q      <= 1'b0;
              first_q      <= 1'b0;
              last_q       <= 1'b0;
            end else begin
              sel_q   <= sel_d;
              first_q <= 1'b0;
              last_q  <= last_d;
            end
          end
        end
        default: begin
          state_q      <= S_IDLE;
          road_ready_q <= 1'b1;
          valid_q      <= 1'b0;
        end
      endcase
    end
  end

  assign road_ready  = road_ready_q;
  assign comb_valid  = valid_q;
  assign comb_sel    = sel_q;
  assign comb_hitmap = hitmap_q;
  assign comb_lcmap  = lcmap_q;
  assign comb_first  = first_q;
  assign comb_last   = last_q;
  assign comb_err    = err_q;
  assign fitset      = fitset_q;

endmodule

// File: tb/tb_hit_comb_gen.sv
// Bench for hit_comb_gen: table of roads, expected beats queued at road
// issue and compared beat by beat, plus a reset-abort sequence.
module tb_hit_comb_gen;
  localparam int unsigned NLAYER = 5;
  localparam int unsigned CNT_W  = 3;

  logic                    clock;
  logic                    reset;
  logic                    road_valid;
  logic                    road_ready;
  logic [NLAYER-1:0]       hitmap_in;
  logic [NLAYER-1:0]       lcmap_in;
  logic [NLAYER*CNT_W-1:0] nhits_in;
  logic                    comb_valid;
  logic                    comb_ready;
  logic [NLAYER*CNT_W-1:0] comb_sel;
  logic [NLAYER-1:0]       comb_hitmap;
  logic [NLAYER-1:0]       comb_lcmap;
  logic                    comb_first;
  logic                    comb_last;
  logic                    comb_err;
  logic [2:0]              fitset;

  hit_comb_gen #(.NLAYER(NLAYER), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .road_valid(road_valid), .road_ready(road_ready),
    .hitmap_in(hitmap_in), .lcmap_in(lcmap_in), .nhits_in(nhits_in),
    .comb_valid(comb_valid), .comb_ready(comb_ready),
    .comb_sel(comb_sel), .comb_hitmap(comb_hitmap), .comb_lcmap(comb_lcmap),
    .comb_first(comb_first), .comb_last(comb_last), .comb_err(comb_err),
    .fitset(fitset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [NLAYER-1:0]       hm;
    logic [NLAYER-1:0]       lc;
    logic [NLAYER*CNT_W-1:0] nh;
    int                      mode;   // 0: ready always high, 1: ready 1,0,0 repeating
    logic [NLAYER-1:0]       e_hm;
    logic [NLAYER-1:0]       e_lc;
    logic [2:0]              e_fit;
    logic                    e_err;
    int                      e_nb;
  } road_t;

  typedef struct {
    logic [NLAYER*CNT_W-1:0] sel;
    logic [NLAYER-1:0]       hm;
    logic [NLAYER-1:0]       lc;
    logic                    first;
    logic                    last;
    logic                    err;
    logic [2:0]              fit;
  } beat_t;

  beat_t q[$];
  road_t vecs[8];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NLAYER*CNT_W-1:0] pk(input int c0, input int c1,
                                                 input int c2, input int c3, input int c4);
    return {3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},  32'(comb_valid), 0);
    chk({tag, "_rready"}, 32'(road_ready), 1);
    chk({tag, "_sel"},    32'(comb_sel), 0);
    chk({tag, "_hm"},     32'(comb_hitmap), 0);
    chk({tag, "_lc"},     32'(comb_lcmap), 0);
    chk({tag, "_first"},  32'(comb_first), 0);
    chk({tag, "_last"},   32'(comb_last), 0);
    chk({tag, "_err"},    32'(comb_err), 0);
    chk({tag, "_fit"},    32'(fitset), 0);
  endtask

  // Issues a road and checks every beat; abort_at >= 0 pulses reset when
  // that many beats have been accepted.
  task automatic run_road(input road_t v, input int abort_at);
    int cnt[NLAYER];
    int div, popped, cyc, budget, nb;
    beat_t b;
    for (int k = 0; k < 20 && !road_ready; k++) @(negedge clock);
    chk("road_ready_wait", 32'(road_ready), 1);
    for (int i = 0; i < NLAYER; i++)
      cnt[i] = (v.e_hm[i] && !v.e_err) ? int'(v.nh[i*CNT_W +: CNT_W]) : 1;
    nb = v.e_err ? 1 : v.e_nb;
    for (int n = 0; n < nb; n++) begin
      div = 1;
      b.sel = '0;
      for (int i = 0; i < NLAYER; i++) begin
        b.sel[i*CNT_W +: CNT_W] = 3'((n / div) % cnt[i]);
        div = div * cnt[i];
      end
      b.hm = v.e_hm; b.lc = v.e_lc; b.err = v.e_err; b.fit = v.e_fit;
      b.first = (n == 0); b.last = (n == nb - 1);
      q.push_back(b);
    end
    road_valid = 1'b1;
    hitmap_in  = v.hm;
    lcmap_in   = v.lc;
    nhits_in   = v.nh;
    comb_ready = (v.mode == 0);
    @(negedge clock);
    road_valid = 1'b0;
    hitmap_in  = '0;
    nhits_in   = '0;
    popped = 0;
    cyc    = 0;
    budget = nb * 3 + 20;
    while (q.size() > 0 && cyc < budget) begin
      chk("valid",  32'(comb_valid), 1);
      chk("rready_run", 32'(road_ready), 0);
      chk("sel",    32'(comb_sel), 32'(q[0].sel));
      chk("hitmap", 32'(comb_hitmap), 32'(q[0].hm));
      chk("lcmap",  32'(comb_lcmap), 32'(q[0].lc));
      chk("first",  32'(comb_first), 32'(q[0].first));
      chk("last",   32'(comb_last), 32'(q[0].last));
      chk("err",    32'(comb_err), 32'(q[0].err));
      chk("fitset", 32'(fitset), 32'(q[0].fit));
      if (popped == abort_at) begin
        reset = 1'b1;
        comb_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check_reset_outputs("abort");
        q.delete();
        return;
      end
      comb_ready = (v.mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (comb_ready) begin
        void'(q.pop_front());
        popped++;
      end
      @(negedge clock);
      cyc++;
    end
    if (q.size() > 0) begin
      chk("beat_timeout", 32'(q.size()), 0);
      q.delete();
    end
    chk("valid_after_last", 32'(comb_valid), 0);
    chk("rready_after_last", 32'(road_ready), 1);
    comb_ready = 1'b0;
  endtask

  initial begin
    //            hm        lc        nh                  mode e_hm      e_lc      fit   err  nb
    vecs[0] = '{5'b11111, 5'b00100, pk(1,1,1,1,1), 0, 5'b11111, 5'b00100, 3'd5, 1'b0, 1};
    vecs[1] = '{5'b11111, 5'b00000, pk(2,3,1,1,1), 0, 5'b11111, 5'b00000, 3'd5, 1'b0, 6};
    vecs[2] = '{5'b11111, 5'b11111, pk(1,1,1,0,1), 0, 5'b10111, 5'b10111, 3'd3, 1'b0, 1};
    vecs[3] = '{5'b10110, 5'b11111, pk(1,1,1,1,1), 0, 5'b10110, 5'b10110, 3'd7, 1'b1, 1};
    vecs[4] = '{5'b11111, 5'b00001, pk(1,1,2,1,2), 1, 5'b11111, 5'b00001, 3'd5, 1'b0, 4};
    vecs[5] = '{5'b01111, 5'b10010, pk(3,1,1,1,5), 0, 5'b01111, 5'b00010, 3'd4, 1'b0, 3};
    vecs[6] = '{5'b11011, 5'b01110, pk(2,0,7,1,4), 1, 5'b11001, 5'b01000, 3'd7, 1'b1, 1};
    vecs[7] = '{5'b11111, 5'b01010, pk(2,2,2,2,3), 1, 5'b11111, 5'b01010, 3'd5, 1'b0, 48};

    reset = 1'b1; road_valid = 1'b0; comb_ready = 1'b0;
    hitmap_in = '0; lcmap_in = '0; nhits_in = '0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    // comb_ready high while idle must not disturb anything
    comb_ready = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_outputs("idle_ready");

    for (int n = 0; n < 8; n++) run_road(vecs[n], -1);

    // Abort a 6-beat road during beat 2, then a fresh road starts clean
    run_road(vecs[1], 1);
    run_road(vecs[1], -1);

    // Largest road: every layer at 7 hits
    run_road('{5'b11111, 5'b00000, pk(7,7,7,7,7), 0, 5'b11111, 5'b00000, 3'd5, 1'b0, 16807}, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
